ones_count_accum: RTL and testbench



---
 rtl/oca_pkg.sv | 16 +
 rtl/ones_count_accum_if.sv | 38 +++
 rtl/oca_ctrl.sv | 77 +++++++
 rtl/ones_count_accum.sv | 105 ++++++++++
 tb/tb_ones_count_accum.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/oca_pkg.sv
// Shared types and sizing helpers for the ones-count frame accumulator.
package oca_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } oca_state_t;

  typedef logic [1:0] cnt_t;

  // The total never exceeds 3*frame_len, so this width cannot overflow.
  function automatic int oca_cnt_w(input int frame_len);
    return $clog2(3 * frame_len + 1);
  endfunction

endpackage

// File: rtl/ones_count_accum_if.sv
// Word input and frame-total output ports of ones_count_accum.
// out_above exists only when OCA_THRESH_EN is defined.
interface ones_count_accum_if
  import oca_pkg::*;
#(
  parameter int CNT_W = 5
);
  // Both ports are valid/ready: a transfer happens on a rising edge where
  // valid and ready are both 1; the source holds its payload until then.
  logic             in_valid;
  logic             in_ready;
  cnt_t             in_cnt;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [7:0]       out_words;
`ifdef OCA_THRESH_EN
  logic             out_above;
`endif

  modport master (
    output in_valid, in_cnt, in_last, out_ready,
    input  in_ready, out_valid, out_count, out_words
`ifdef OCA_THRESH_EN
    , input out_above
`endif
  );

  modport slave (
    input  in_valid, in_cnt, in_last, out_ready,
    output in_ready, out_valid, out_count, out_words
`ifdef OCA_THRESH_EN
    , output out_above
`endif
  );

endinterface

// File: rtl/oca_ctrl.sv
// Frame FSM and word counter: decides accept, frame end, clear and handshake
// strobes for the accumulator datapath.
module oca_ctrl
  import oca_pkg::*;
#(
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       in_valid_i,
  input  logic       in_last_i,
  input  logic       out_ready_i,
  output logic       in_ready_o,
  output logic       acc_en_o,
  output logic       load_o,
  output logic       acc_clr_o,
  output logic       drop_o,
  output logic [7:0] word_cnt_o,
  output oca_state_t state_o
);

  oca_state_t state_q, state_d;
  logic [7:0] word_cnt_q, word_cnt_d;
  logic       accept;
  logic       final_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACC;
      word_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign accept     = in_valid_i && (state_q == ACC);
  assign final_word = accept && (in_last_i || (word_cnt_q == 8'(FRAME_LEN - 1)));

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    acc_en_o   = 1'b0;
    load_o     = 1'b0;
    acc_clr_o  = 1'b0;
    drop_o     = 1'b0;
    unique case (state_q)
      ACC: begin
        // clr beats a same-cycle accept: the word is discarded.
        if (clr_i) begin
          acc_clr_o  = 1'b1;
          word_cnt_d = 8'd0;
        end else if (final_word) begin
          load_o     = 1'b1;
          word_cnt_d = 8'd0;
          state_d    = DONE;
        end else if (accept) begin
          acc_en_o   = 1'b1;
          word_cnt_d = word_cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (clr_i || out_ready_i) begin
          drop_o  = 1'b1;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  assign in_ready_o = (state_q == ACC);
  assign word_cnt_o = word_cnt_q;
  assign state_o    = state_q;

endmodule

// File: rtl/ones_count_accum.sv
// Frame popcount accumulator: sums 2-bit ones counts over a frame and offers
// the total on a valid/ready port. Optional macro OCA_THRESH_EN adds out_above.
module ones_count_accum
  import oca_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = oca_cnt_w(FRAME_LEN)
`ifdef OCA_THRESH_EN
  , parameter int THRESH  = 12
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  ones_count_accum_if.slave   bus,
  output oca_state_t          dbg_state_o
);

  logic             acc_en, load, acc_clr, drop;
  logic [7:0]       word_cnt;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] sum;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [7:0]       out_words_q, out_words_d;
  logic             out_valid_q, out_valid_d;

  oca_ctrl #(.FRAME_LEN(FRAME_LEN)) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .in_valid_i  (bus.in_valid),
    .in_last_i   (bus.in_last),
    .out_ready_i (bus.out_ready),
    .in_ready_o  (bus.in_ready),
    .acc_en_o    (acc_en),
    .load_o      (load),
    .acc_clr_o   (acc_clr),
    .drop_o      (drop),
    .word_cnt_o  (word_cnt),
    .state_o     (dbg_state_o)
  );

  assign sum = acc_q + CNT_W'(bus.in_cnt);

  always_comb begin
    acc_d       = acc_q;
    out_count_d = out_count_q;
    out_words_d = out_words_q;
    out_valid_d = out_valid_q;
    if (acc_clr || load) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = sum;
    end
    if (load) begin
      out_count_d = sum;
      out_words_d = word_cnt + 8'd1;
      out_valid_d = 1'b1;
    end else if (drop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      out_count_q <= '0;
      out_words_q <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_count_q <= out_count_d;
      out_words_q <= out_words_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
  assign bus.out_words = out_words_q;

`ifdef OCA_THRESH_EN
  logic out_above_q, out_above_d;

  always_comb begin
    out_above_d = out_above_q;
    if (clr) begin
      out_above_d = 1'b0;
    end else if (load) begin
      out_above_d = (int'(sum) > THRESH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_above_q <= 1'b0;
    end else begin
      out_above_q <= out_above_d;
    end
  end

  assign bus.out_above = out_above_q;
`endif

endmodule

// File: tb/tb_ones_count_accum.sv
// Directed bench for ones_count_accum with FRAME_LEN=8 (CNT_W=5).
// Threshold checks are included when OCA_THRESH_EN is defined.
module tb_ones_count_accum;
  import oca_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       clr;
  oca_state_t dbg_state;
  int         errors;
  int         checks;

  ones_count_accum_if #(.CNT_W(5)) bus ();

  ones_count_accum #(.FRAME_LEN(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic word(input logic [1:0] cnt, input logic last);
    bus.in_valid = 1'b1;
    bus.in_cnt   = cnt;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [4:0] c, input logic [7:0] w);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(c));
    chk({tag, "_words"}, 32'(bus.out_words), 32'(w));
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_cnt    = 2'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk_out("rst", 1'b0, 5'd0, 8'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef OCA_THRESH_EN
    chk("rst_above", 32'(bus.out_above), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Full frame of 3s back to back: 24 over 8 words, one-cycle bubble
    bus.in_valid = 1'b1;
    bus.in_cnt   = 2'd3;
    for (int i = 0; i < 7; i++) tick();
    chk_out("full_pre", 1'b0, 5'd0, 8'd0);
    tick();
    bus.in_valid = 1'b0;
    chk_out("full", 1'b1, 5'd24, 8'd8);
    chk("full_bubble", 32'(bus.in_ready), 32'd0);
    tick();
    chk("full_hs_valid", 32'(bus.out_valid), 32'd0);
    chk("full_hs_ready", 32'(bus.in_ready), 32'd1);

    // Early end on 4th word: 1+0+2+3 = 6
    word(2'd1, 1'b0);
    word(2'd0, 1'b0);
    word(2'd2, 1'b0);
    word(2'd3, 1'b1);
    chk_out("early", 1'b1, 5'd6, 8'd4);
    tick();
    word(2'd2, 1'b1);
    chk_out("after_early", 1'b1, 5'd2, 8'd1);
    tick();

    // Backpressure: total 10 held while upstream keeps a word pending
    bus.out_ready = 1'b0;
    word(2'd3, 1'b0);
    word(2'd3, 1'b0);
    word(2'd2, 1'b0);
    word(2'd2, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_cnt   = 2'd1;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_out("hold", 1'b1, 5'd10, 8'd4);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("hold_hs_valid", 32'(bus.out_valid), 32'd0);
    chk("hold_hs_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk_out("held_word", 1'b1, 5'd1, 8'd1);
    tick();

    // clr with a simultaneous accept after acc=5
    word(2'd3, 1'b0);
    word(2'd2, 1'b0);
    clr = 1'b1;
    word(2'd2, 1'b0);
    clr = 1'b0;
    chk("clr_no_out", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 7; i++) word(2'd1, 1'b0);
    chk("clr_not_early", 32'(bus.out_valid), 32'd0);
    word(2'd1, 1'b1);
    chk_out("clr_frame", 1'b1, 5'd8, 8'd8);
    tick();
    chk("single_end", 32'(bus.out_valid), 32'd0);
    tick();
    chk("single_end2", 32'(bus.out_valid), 32'd0);

    // clr in DONE drops the pending result
    bus.out_ready = 1'b0;
    word(2'd2, 1'b1);
    chk("clr_done_pre", 32'(bus.out_valid), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_done_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_done_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;

    // Async reset mid-frame (acc=7)
    word(2'd3, 1'b0);
    word(2'd3, 1'b0);
    word(2'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid", 1'b0, 5'd0, 8'd0);
    chk("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    word(2'd1, 1'b1);
    chk_out("post_rst", 1'b1, 5'd1, 8'd1);

    // Async reset while out_valid=1
    bus.out_ready = 1'b0;
    tick();
    chk("rst_done_pre", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_out("rst_done", 1'b0, 5'd0, 8'd0);
    chk("rst_done_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("rst_done_rel", 32'(bus.in_ready), 32'd1);
    chk("rst_done_nopulse", 32'(bus.out_valid), 32'd0);

`ifdef OCA_THRESH_EN
    for (int i = 0; i < 3; i++) word(2'd3, 1'b0);
    word(2'd3, 1'b1);
    chk_out("th12", 1'b1, 5'd12, 8'd4);
    chk("th12_above", 32'(bus.out_above), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) word(2'd3, 1'b0);
    word(2'd1, 1'b1);
    chk_out("th13", 1'b1, 5'd13, 8'd5);
    chk("th13_above", 32'(bus.out_above), 32'd1);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("th_clr_above", 32'(bus.out_above), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
